// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader: word-serial bitstream loader that checks a trailing XOR checksum and atomically commits to fabric config buses.
// Latency: active config, cfg_done and fab_reset update one cycle after the checksum word is accepted; cfg_ready rises one cycle after cfg_start.
// Backpressure: cfg_ready is registered and high only in LOAD/CHECK; cfg_valid while cfg_ready=0 is ignored with no side effect.
//
// Ports:
//   clk, reset           - single clock, synchronous active-high reset
//   cfg_start            - begin or restart a load (ignored during COMMIT)
//   cfg_data/cfg_valid   - stream word and its valid; cfg_ready is the loader's ready
//   sramConfig/cbconfig/sconfig - active logic-block / connection-block / switch-box config
//   fab_reset            - fabric reset: high in reset, one cycle after release, and for one cycle on commit
//   cfg_done             - one-cycle pulse on successful commit
//   cfg_err              - sticky checksum-failure flag, cleared when a new load starts
module fabric_cfg_loader #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int DW   = 32,
  parameter int LB_W = 16,
  parameter int CB_W = 35,
  parameter int SB_W = 60,
  localparam int N_LB  = ROWS * COLS,
  localparam int N_CB  = ROWS * (COLS - 1) + COLS * (ROWS - 1),
  localparam int N_SB  = (ROWS - 1) * (COLS - 1),
  localparam int TOTAL = N_LB * LB_W + N_CB * CB_W + N_SB * SB_W,
  localparam int WORDS = (TOTAL + DW - 1) / DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [DW-1:0]        cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [N_LB*LB_W-1:0] sramConfig,
  output logic [N_CB*CB_W-1:0] cbconfig,
  output logic [N_SB*SB_W-1:0] sconfig,
  output logic                 fab_reset,
  output logic                 cfg_done,
  output logic                 cfg_err
);

  localparam int CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT,
    ERROR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [DW-1:0]    xor_acc;
  // Only the low TOTAL bits of the word-serial image are ever committed; the
  // leading pad bits shift off the top here and only reach the checksum.
  logic [TOTAL-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cfg_ready  <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      fab_reset  <= 1'b1;
      word_cnt   <= '0;
      xor_acc    <= '0;
      shadow     <= '0;
      sramConfig <= '0;
      cbconfig   <= '0;
      sconfig    <= '0;
    end else begin
      cfg_done  <= 1'b0;
      fab_reset <= 1'b0;
      // Start/restart wins over any word presented in the same cycle, so an
      // aborted load leaves no partial count or checksum behind.
      if (cfg_start && state != COMMIT) begin
        state     <= LOAD;
        cfg_ready <= 1'b1;
        cfg_err   <= 1'b0;
        word_cnt  <= '0;
        xor_acc   <= '0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            if (cfg_valid) begin
              shadow   <= TOTAL'({shadow, cfg_data});
              xor_acc  <= xor_acc ^ cfg_data;
              word_cnt <= word_cnt + CNT_W'(1);
              if (word_cnt == LAST_WORD) begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (cfg_valid) begin
              cfg_ready <= 1'b0;
              if (xor_acc == cfg_data) begin
                state <= COMMIT;
              end else begin
                state   <= ERROR;
                cfg_err <= 1'b1;
              end
            end
          end
          COMMIT: begin
            {sramConfig, cbconfig, sconfig} <= shadow;
            cfg_done  <= 1'b1;
            fab_reset <= 1'b1;
            state     <= IDLE;
          end
          ERROR: ;
          default: begin
            state     <= IDLE;
            cfg_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
